serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t        - controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  - default operand/result width in bits
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit subtractor cell computing x - y - bin.
// Ports:
//   x    in   minuend bit
//   y    in   subtrahend bit
//   bin  in   borrow from the less significant bit
//   d    out  difference bit
//   bout out  borrow to the more significant bit
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: diff = a - b modulo 2^WIDTH, one bit per
// clock, LSB first, through a single full_subtractor cell.
// A start accepted in IDLE loads the operands; WIDTH SHIFT cycles follow,
// then one DONE cycle in which done pulses. diff/borrow_out hold until the
// next accepted start.
//
// Parameters:
//   WIDTH       operand/result width, 2..32
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (priority over start)
//   start       operation request, sampled only in IDLE
//   a, b        minuend / subtrahend, captured on the accepted start
//   busy        high in SHIFT and DONE
//   done        one-cycle result-valid pulse
//   diff        result
//   borrow_out  final borrow (a < b unsigned)
//   ovf         signed overflow flag, only when SERIAL_SUBTRACTOR_OVF_EN
//               is defined
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic             borrow_q;
    logic             cell_d, cell_bout;
    logic             last;

    assign last = (cnt == LAST);

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        cnt      <= '0;
                        diff_sr  <= '0;
                        borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf      <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // Operands shift right so bit 0 always feeds the cell;
                    // result bits enter at the MSB and walk down, so after
                    // WIDTH shifts the first (LSB) result sits at bit 0.
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    diff_sr  <= {cell_d, diff_sr[WIDTH-1:1]};
                    borrow_q <= cell_bout;
                    cnt      <= last ? '0 : cnt + CW'(1);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // On the last shift the cell sees the operand MSBs and
                    // produces the result MSB, so no extra sign storage.
                    if (last)
                        ovf <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign diff       = diff_sr;
    assign borrow_out = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           cyc;
        string        name;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: cycle %0d diff=%h, no request outstanding", cyc, diff);
            end else begin
                e = q.pop_front();
                if (diff !== e.d || borrow_out !== e.bo || cyc != e.cyc
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    || ovf !== e.ov
`endif
                   ) begin
                    n_fail++;
                    $display("FAIL %s: got diff=%h borrow=%b cycle=%0d, expected diff=%h borrow=%b ovf=%b cycle=%0d",
                             e.name, diff, borrow_out, cyc, e.d, e.bo, e.ov, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy !== 1'b0) begin
            n_vec++; n_fail++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, k);
        end
    endtask

    // Issue one start from IDLE; the accepted edge is the next posedge.
    task automatic op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ed, input logic ebo, input logic eov);
        exp_t e;
        wait_idle();
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~av; b = ~bv;      // later operand changes must not matter
        e.d = ed; e.bo = ebo; e.ov = eov; e.cyc = cyc + W; e.name = name;
        q.push_back(e);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc_prev, acc;
        exp_t e;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_diff", {24'd0, diff}, 32'd0);
        check("reset_borrow", {31'd0, borrow_out}, 32'd0);
        // rst wins over start
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_priority_busy", {31'd0, busy}, 32'd0);
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        op("200-55",   8'd200, 8'd55,  8'h91, 1'b0, 1'b0);
        op("5-10",     8'd5,   8'd10,  8'hFB, 1'b1, 1'b0);
        op("0-1",      8'd0,   8'd1,   8'hFF, 1'b1, 1'b0);
        op("5A-5A",    8'h5A,  8'h5A,  8'h00, 1'b0, 1'b0);
        op("80-01",    8'h80,  8'h01,  8'h7F, 1'b0, 1'b1);
        op("7F-FF",    8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1);
        op("10-01",    8'h10,  8'h01,  8'h0F, 1'b0, 1'b0);
        op("FF-00",    8'hFF,  8'h00,  8'hFF, 1'b0, 1'b0);
        op("00-FF",    8'h00,  8'hFF,  8'h01, 1'b1, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        check("hold_diff", {24'd0, diff}, 32'h01);
        check("hold_borrow", {31'd0, borrow_out}, 32'd1);

        // start during SHIFT is dropped
        op("9-3_ignore_start", 8'd9, 8'd3, 8'd6, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (W + 4) @(posedge clk);
        #1;
        check("dropped_start_busy", {31'd0, busy}, 32'd0);

        // reset in the 4th SHIFT cycle aborts silently
        wait_idle();
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_borrow", {31'd0, borrow_out}, 32'd0);
        repeat (W + 4) @(posedge clk);
        #1;
        check("abort_no_busy", {31'd0, busy}, 32'd0);
        op("7-2_after_rst", 8'd7, 8'd2, 8'd5, 1'b0, 1'b0);

        // start held high: back-to-back operations, W+2 apart
        wait_idle();
        acc_prev = 0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [W-1:0] av, bv;
            int t = 0;
            while (busy !== 1'b0 && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            check($sformatf("held_idle_%0d", k), {31'd0, busy}, 32'd0);
            case (k)
                0:       begin av = 8'd50;  bv = 8'd20;  e.d = 8'd30;  e.bo = 1'b0; e.ov = 1'b0; end
                1:       begin av = 8'd20;  bv = 8'd50;  e.d = 8'hE2;  e.bo = 1'b1; e.ov = 1'b0; end
                default: begin av = 8'hC0;  bv = 8'h40;  e.d = 8'h80;  e.bo = 1'b0; e.ov = 1'b0; end
            endcase
            a = av; b = bv;
            @(posedge clk); #1;
            acc = cyc;
            a = 8'hAA; b = 8'h55;
            e.cyc = acc + W;
            e.name = $sformatf("held_op_%0d", k);
            q.push_back(e);
            if (k > 0) check($sformatf("held_spacing_%0d", k), acc - acc_prev, W + 2);
            acc_prev = acc;
        end
        start = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
